// File: rtl/cache_controller.sv
// cache_controller: two-level (L1/L2) direct-mapped, write-through, write-allocate cache model
// with fixed lookup latencies and no backing memory (a miss in both levels reads as zero).
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous reset, active-low
//   wr_en     in   1          1 = write request, 0 = read request (sampled in idle only)
//   addr      in   WORD_SIZE  word address of the request
//   data      in   WORD_SIZE  write data
//   data_out  out  WORD_SIZE  registered read result; holds the last read value
//
// Timing (edge 0 is the idle edge that captures the request):
//   L1 hit              -> data_out updated at edge L1_DELAY
//   L2 hit / full miss  -> data_out updated at edge L1_DELAY+L2_DELAY
//   write               -> arrays updated at edge L1_DELAY+L2_DELAY, data_out untouched
module cache_controller #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned L1_DELAY  = 3,
    parameter int unsigned L2_DELAY  = 3,
    parameter int unsigned L1_LINES  = 16,
    parameter int unsigned L2_LINES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data,
    output logic [WORD_SIZE-1:0] data_out
);

    localparam int unsigned L1_IW = $clog2(L1_LINES);
    localparam int unsigned L2_IW = $clog2(L2_LINES);
    localparam int unsigned L1_TW = WORD_SIZE - L1_IW;
    localparam int unsigned L2_TW = WORD_SIZE - L2_IW;
    localparam int unsigned CNT_W = $clog2(L1_DELAY + L2_DELAY + 1);

    localparam logic [CNT_W-1:0] L1_CNT  = CNT_W'(L1_DELAY);
    localparam logic [CNT_W-1:0] L2_CNT  = CNT_W'(L2_DELAY);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(L1_DELAY + L2_DELAY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StL1Lookup,
        StL2Lookup,
        StWrite
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WORD_SIZE-1:0] req_addr_q;
    logic [WORD_SIZE-1:0] req_data_q;

    logic [L1_LINES-1:0]  l1_valid_q;
    logic [L1_TW-1:0]     l1_tag_q  [L1_LINES];
    logic [WORD_SIZE-1:0] l1_data_q [L1_LINES];

    logic [L2_LINES-1:0]  l2_valid_q;
    logic [L2_TW-1:0]     l2_tag_q  [L2_LINES];
    logic [WORD_SIZE-1:0] l2_data_q [L2_LINES];

    // Lookups always use the captured request, never the live input port.
    logic [L1_IW-1:0] l1_idx;
    logic [L1_TW-1:0] l1_tag;
    logic [L2_IW-1:0] l2_idx;
    logic [L2_TW-1:0] l2_tag;
    logic             l1_hit;
    logic             l2_hit;

    always_comb begin
        l1_idx = req_addr_q[L1_IW-1:0];
        l1_tag = req_addr_q[WORD_SIZE-1:L1_IW];
        l2_idx = req_addr_q[L2_IW-1:0];
        l2_tag = req_addr_q[WORD_SIZE-1:L2_IW];
        l1_hit = l1_valid_q[l1_idx] && (l1_tag_q[l1_idx] == l1_tag);
        l2_hit = l2_valid_q[l2_idx] && (l2_tag_q[l2_idx] == l2_tag);
    end

    // cnt_q counts edges since the capturing edge of the current phase; each phase
    // starts at 1 so that the decision lands exactly on edge DELAY of that phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            l1_valid_q <= '0;
            l2_valid_q <= '0;
            data_out   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_addr_q <= addr;
                    req_data_q <= data;
                    cnt_q      <= CNT_ONE;
                    state_q    <= wr_en ? StWrite : StL1Lookup;
                end
                StL1Lookup: begin
                    if (cnt_q == L1_CNT) begin
                        if (l1_hit) begin
                            data_out <= l1_data_q[l1_idx];
                            state_q  <= StIdle;
                        end else begin
                            cnt_q   <= CNT_ONE;
                            state_q <= StL2Lookup;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StL2Lookup: begin
                    if (cnt_q == L2_CNT) begin
                        if (l2_hit) begin
                            data_out           <= l2_data_q[l2_idx];
                            l1_valid_q[l1_idx] <= 1'b1;
                            l1_tag_q[l1_idx]   <= l1_tag;
                            l1_data_q[l1_idx]  <= l2_data_q[l2_idx];
                        end else begin
                            data_out <= '0;
                        end
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StWrite: begin
                    if (cnt_q == WR_CNT) begin
                        l1_valid_q[l1_idx] <= 1'b1;
                        l1_tag_q[l1_idx]   <= l1_tag;
                        l1_data_q[l1_idx]  <= req_data_q;
                        l2_valid_q[l2_idx] <= 1'b1;
                        l2_tag_q[l2_idx]   <= l2_tag;
                        l2_data_q[l2_idx]  <= req_data_q;
                        state_q            <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table, hand-written reset/drop
// sequences, then randomized traffic checked against an address-keyed reference model.
module tb_cache_controller;

    localparam int unsigned L1D  = 3;
    localparam int unsigned L2D  = 3;
    localparam int unsigned L1N  = 16;
    localparam int unsigned L2N  = 64;
    localparam int          FULL = L1D + L2D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] prev_out = '0;

    cache_controller #(
        .WORD_SIZE(32),
        .L1_DELAY (L1D),
        .L2_DELAY (L2D),
        .L1_LINES (L1N),
        .L2_LINES (L2N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .addr    (addr),
        .data    (data),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Reference model: each level remembers which full address occupies a slot.
    bit          m1_v    [L1N];
    logic [31:0] m1_addr [L1N];
    logic [31:0] m1_dat  [L1N];
    bit          m2_v    [L2N];
    logic [31:0] m2_addr [L2N];
    logic [31:0] m2_dat  [L2N];
    logic [31:0] m_out;

    function automatic void model_reset();
        for (int i = 0; i < int'(L1N); i++) m1_v[i] = 1'b0;
        for (int i = 0; i < int'(L2N); i++) m2_v[i] = 1'b0;
        m_out = '0;
    endfunction

    function automatic void model_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                     output logic [31:0] ev, output int lat);
        int s1;
        int s2;
        s1 = int'(a % L1N);
        s2 = int'(a % L2N);
        if (wr) begin
            m1_v[s1] = 1'b1; m1_addr[s1] = a; m1_dat[s1] = d;
            m2_v[s2] = 1'b1; m2_addr[s2] = a; m2_dat[s2] = d;
            lat = FULL;
        end else if (m1_v[s1] && m1_addr[s1] == a) begin
            m_out = m1_dat[s1];
            lat   = L1D;
        end else if (m2_v[s2] && m2_addr[s2] == a) begin
            m_out = m2_dat[s2];
            m1_v[s1] = 1'b1; m1_addr[s1] = a; m1_dat[s1] = m2_dat[s2];
            lat   = FULL;
        end else begin
            m_out = '0;
            lat   = FULL;
        end
        ev = m_out;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one request on the next (idle) edge and checks data_out one edge before and at
    // the expected completion edge. noise: 0 quiet, 1 random inputs while busy,
    // 2 a 0x40=DEADBEEF write pulse while busy.
    task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input int lat, input int noise,
                         input string name);
        wr_en = wr; addr = a; data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (noise == 1) begin
                wr_en = 1'($urandom_range(0, 1)); addr = $urandom; data = $urandom;
            end else if (noise == 2 && k == 1) begin
                wr_en = 1'b1; addr = 32'h40; data = 32'hDEADBEEF;
            end else if (noise == 2 && k == 2) begin
                wr_en = 1'b0;
            end
            @(posedge clk); #1;
            if (k == lat - 1) check({name, "_early"}, data_out, prev_out);
        end
        check(name, data_out, exp);
        prev_out = exp;
        wr_en = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] ev;
        int          lat;

        vecs[0] = '{1'b0, 32'h10, 32'h0,        32'h0,        6};
        vecs[1] = '{1'b1, 32'h10, 32'hA5A5A5A5, 32'h0,        6};
        vecs[2] = '{1'b0, 32'h10, 32'h0,        32'hA5A5A5A5, 3};
        vecs[3] = '{1'b0, 32'h11, 32'h0,        32'h0,        6};
        vecs[4] = '{1'b1, 32'h20, 32'h5A5A5A5A, 32'h0,        6};
        vecs[5] = '{1'b1, 32'h30, 32'h12345678, 32'h0,        6};
        vecs[6] = '{1'b0, 32'h20, 32'h0,        32'h5A5A5A5A, 6};
        vecs[7] = '{1'b0, 32'h20, 32'h0,        32'h5A5A5A5A, 3};
        vecs[8] = '{1'b0, 32'h30, 32'h0,        32'h12345678, 6};
        vecs[9] = '{1'b0, 32'h10, 32'h0,        32'hA5A5A5A5, 6};

        // Reset
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_data_out", data_out, 32'h0);
        rst = 1'b1;
        model_reset();
        prev_out = '0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            model_op(vecs[i].wr, vecs[i].a, vecs[i].d, ev, lat);
            if (ev !== vecs[i].exp || lat != vecs[i].lat)
                $display("NOTE vector %0d: model predicts %h after %0d", i, ev, lat);
            do_op(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].lat, 0,
                  $sformatf("vec%0d", i));
        end

        // Write pulse during a read must be dropped
        model_op(1'b0, 32'h10, 32'h0, ev, lat);
        do_op(1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 3, 2, "read_with_dropped_write");
        model_op(1'b0, 32'h40, 32'h0, ev, lat);
        do_op(1'b0, 32'h40, 32'h0, 32'h0, 6, 0, "dropped_write_absent");

        // Make data_out non-zero, then reset in the middle of a write to 0x50
        model_op(1'b0, 32'h10, 32'h0, ev, lat);
        do_op(1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 3, 0, "pre_reset_read");
        wr_en = 1'b1; addr = 32'h50; data = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_write_reset_data_out", data_out, 32'h0);
        rst = 1'b1;
        model_reset();
        prev_out = '0;
        model_op(1'b0, 32'h50, 32'h0, ev, lat);
        do_op(1'b0, 32'h50, 32'h0, 32'h0, 6, 0, "aborted_write_absent");
        model_op(1'b0, 32'h10, 32'h0, ev, lat);
        do_op(1'b0, 32'h10, 32'h0, 32'h0, 6, 0, "reset_cleared_lines");

        // Randomized traffic on a small address pool so hits, conflicts and refills occur
        for (int n = 0; n < 300; n++) begin
            bit          wr;
            logic [31:0] a;
            logic [31:0] d;
            wr = ($urandom_range(0, 9) < 4);
            a  = 32'($urandom_range(0, 127));
            d  = $urandom;
            model_op(wr, a, d, ev, lat);
            do_op(wr, a, d, ev, lat, 1, $sformatf("rand%0d_%s_%h", n, wr ? "wr" : "rd", a));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
